pipe_stage_reg: RTL and testbench

//  Generic parametrised inter-stage pipeline register for the MIPS pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_stage_reg_if.sv | 22 ++
 rtl/pipe_stage_reg.sv | 94 +++++++++
 tb/tb_pipe_stage_reg.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle for pipe_stage_reg: upstream valid/ready/data and downstream valid/ready/data.
// slave is the stage's view; master is the view of whatever feeds and drains it.
interface pipe_stage_reg_if #(
  parameter int unsigned DATA_W = 64
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, hazard stall, flush-to-bubble and perf counters.
// Define PIPE_STAGE_SKID_EN to add a skid register that removes the out_ready -> in_ready path.
module pipe_stage_reg #(
  parameter int unsigned       DATA_W     = 64,
  parameter logic [DATA_W-1:0] RESET_VAL  = '0,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
  parameter int unsigned       CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  pipe_stage_reg_if.slave  bus,
  input  logic             stall,
  input  logic             flush,
  output logic [1:0]       level,
  output logic [CNT_W-1:0] stall_cnt
);
  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic              ready;
  logic              accept;
  logic              deliver;

  assign accept        = bus.in_valid && ready;
  assign deliver       = valid_q && bus.out_ready;
  assign bus.in_ready  = ready;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_valid_q;
  logic [DATA_W-1:0] skid_data_q;

  assign ready = !stall && !skid_valid_q;
  assign level = {1'b0, valid_q} + {1'b0, skid_valid_q};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q      <= 1'b0;
      data_q       <= RESET_VAL;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else if (flush) begin
      valid_q      <= 1'b0;
      data_q       <= BUBBLE_VAL;
      skid_valid_q <= 1'b0;
    end else if (deliver) begin
      // A full skid holds the older beat and also keeps ready low, so no accept can race it.
      if (skid_valid_q) begin
        data_q       <= skid_data_q;
        skid_valid_q <= 1'b0;
      end else if (accept) begin
        data_q <= bus.in_data;
      end else begin
        valid_q <= 1'b0;
      end
    end else if (accept) begin
      if (valid_q) begin
        skid_data_q  <= bus.in_data;
        skid_valid_q <= 1'b1;
      end else begin
        data_q  <= bus.in_data;
        valid_q <= 1'b1;
      end
    end
  end
`else
  assign ready = !stall && (!valid_q || bus.out_ready);
  assign level = {1'b0, valid_q};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= RESET_VAL;
    end else if (flush) begin
      valid_q <= 1'b0;
      data_q  <= BUBBLE_VAL;
    end else if (accept) begin
      data_q  <= bus.in_data;
      valid_q <= 1'b1;
    end else if (deliver) begin
      valid_q <= 1'b0;
    end
  end
`endif

  // Back-pressure counter ignores flush; only reset clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (bus.in_valid && !ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: stimulus script queues expected beats, a negedge monitor checks deliveries.
module tb_pipe_stage_reg;
  localparam int unsigned DW = 32;
  localparam logic [DW-1:0] RV = 32'hDEAD_BEEF;
  localparam logic [DW-1:0] BV = 32'hB0BB_1E00;
`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, flush, stall2, flush2;
  logic [1:0]  level, level2;
  logic [15:0] stall_cnt;
  logic [1:0]  stall_cnt2;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [DW-1:0] exp_q[$];

  pipe_stage_reg_if #(.DATA_W(DW)) bus ();
  pipe_stage_reg_if #(.DATA_W(DW)) bus2 ();

  pipe_stage_reg #(.DATA_W(DW), .RESET_VAL(RV), .BUBBLE_VAL(BV), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .bus(bus), .stall(stall), .flush(flush),
    .level(level), .stall_cnt(stall_cnt)
  );

  pipe_stage_reg #(.DATA_W(DW), .RESET_VAL(RV), .BUBBLE_VAL(BV), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .bus(bus2), .stall(stall2), .flush(flush2),
    .level(level2), .stall_cnt(stall_cnt2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_beat", bus.out_data, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        check("sb_beat", bus.out_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b0; stall = 1'b0; flush = 1'b0; stall2 = 1'b0; flush2 = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 32'h55; bus.out_ready = 1'b1;
    bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.out_ready = 1'b0;

    // Reset held with a valid beat offered
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, RV);
    check("rst_level", level, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    tick();
    reset = 1'b1; bus.in_valid = 1'b0;
    @(negedge clk);
    check("rel_in_ready", bus.in_ready, 1);
    check("rel_out_valid", bus.out_valid, 0);
    tick();

    // Streaming 1..8, no gaps
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      bus.in_valid = 1'b1; bus.in_data = DW'(i);
      @(negedge clk);
      check("stream_in_ready", bus.in_ready, 1);
      check("stream_out_valid", bus.out_valid, (i > 1));
      exp_q.push_back(DW'(i));
      tick();
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("stream_last_valid", bus.out_valid, 1);
    tick();
    @(negedge clk);
    check("stream_level_end", level, 0);
    check("stream_cnt", stall_cnt, 0);
    tick();

    // Back-pressure
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_data = 32'hA1;
    @(negedge clk);
    check("bp_acc0", bus.in_ready, 1);
    exp_q.push_back(32'hA1);
    tick();
    bus.in_data = 32'hB2;
    @(negedge clk);
    check("bp_hold_data", bus.out_data, 32'hA1);
    check("bp_ready", bus.in_ready, SKID);
    if (SKID) exp_q.push_back(32'hB2);
    tick();
    repeat (2) begin
      bus.in_data = SKID ? 32'hC3 : 32'hB2;
      tick();
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_cnt", stall_cnt, SKID ? 2 : 3);
    check("bp_level", level, SKID ? 2 : 1);
    check("bp_hold_data2", bus.out_data, 32'hA1);
    if (!SKID) exp_q.push_back(32'hB2);
    tick();
    bus.in_valid = SKID;
    if (SKID) exp_q.push_back(32'hC3);
    tick();
    bus.in_valid = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("bp_level_end", level, 0);
    check("bp_cnt_end", stall_cnt, 3);
    tick();

    // Stall: held beat drains while input is blocked
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_data = 32'hD4;
    exp_q.push_back(32'hD4);
    tick();
    stall = 1'b1; bus.out_ready = 1'b1; bus.in_data = 32'hE5;
    @(negedge clk);
    check("stall_in_ready", bus.in_ready, 0);
    tick();
    @(negedge clk);
    check("stall_drained", bus.out_valid, 0);
    check("stall_in_ready2", bus.in_ready, 0);
    tick();
    stall = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    check("stall_cnt", stall_cnt, 5);
    tick();

    // Flush with a delivery in the same cycle
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_data = 32'hF1;
    exp_q.push_back(32'hF1);
    tick();
    bus.in_valid = SKID; bus.in_data = 32'hF2;
    tick();
    flush = 1'b1; bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.in_data = 32'hF3;
    @(negedge clk);
    check("flush_pre_level", level, SKID ? 2 : 1);
    check("flush_pre_data", bus.out_data, 32'hF1);
    tick();
    flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    @(negedge clk);
    check("flush_out_valid", bus.out_valid, 0);
    check("flush_bubble", bus.out_data, BV);
    check("flush_level", level, 0);
    check("flush_cnt", stall_cnt, 5 + SKID);
    tick();
    bus.out_ready = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    check("flush_no_beat", bus.out_valid, 0);
    tick();

    // Saturation on CNT_W=2 instance, then async reset between edges
    bus2.in_valid = 1'b1; bus2.in_data = 32'h77; bus2.out_ready = 1'b0;
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_data = 32'h99;
    tick();
    bus.in_valid = 1'b0;
    repeat (6) tick();
    @(negedge clk);
    check("sat_cnt", stall_cnt2, 3);
    check("sat_level", level2, SKID ? 2 : 1);
    check("sat_dut_valid", bus.out_valid, 1);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("arst_out_valid", bus.out_valid, 0);
    check("arst_out_data", bus.out_data, RV);
    check("arst_level", level, 0);
    check("arst_cnt", stall_cnt, 0);
    check("arst_sat_cnt", stall_cnt2, 0);
    check("arst_sat_valid", bus2.out_valid, 0);
    bus2.in_valid = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("arst_in_ready", bus.in_ready, 1);
    tick();

    // Recovery beat after reset
    bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.in_data = 32'h5A;
    exp_q.push_back(32'h5A);
    tick();
    bus.in_valid = 1'b0;
    repeat (2) tick();
    check("sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
